pipe_mips32: RTL and testbench

- Five-stage in-order MIPS32-subset pipeline: IF, ID, EX, MEM, WB.
- Self-contained top-level block with an internal 32x32 register file and a unified 32-bit instruction/data memory.
- The bench loads programs and data by hierarchical writes to internal arrays; it checks results by hierarchical reads.
- Forwarding removes most data hazards; there is no stall logic.

---
 rtl/mips32_pkg.sv | 67 ++++++
 rtl/mips32_alu_if.sv | 11 +
 rtl/mips32_alu.sv | 26 ++
 rtl/pipe_mips32.sv | 172 +++++++++++++++++
 tb/tb_pipe_mips32.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_pkg.sv
// Shared opcode constants, instruction classes and field helpers for the
// five-stage MIPS32-subset pipeline.
package mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd8;
    localparam logic [5:0] OP_SW    = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd10;
    localparam logic [5:0] OP_SUBI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_BNEQZ = 6'd13;
    localparam logic [5:0] OP_BEQZ  = 6'd14;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef enum logic [2:0] {
        RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP
    } itype_t;

    function automatic logic [5:0] f_op(input logic [31:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic [31:0] f_imm(input logic [31:0] ir);
        return {{16{ir[15]}}, ir[15:0]};
    endfunction

    // The halt opcode is a parameter of the core, so it is checked before the
    // fixed opcodes and wins any overlap.
    function automatic itype_t decode_type(input logic [5:0] op, input logic [5:0] halt_op);
        itype_t t;
        if (op == halt_op) begin
            t = HALT;
        end else begin
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = RR_ALU;
                OP_ADDI, OP_SUBI, OP_SLTI:                     t = RM_ALU;
                OP_LW:                                         t = LOAD;
                OP_SW:                                         t = STORE;
                OP_BNEQZ, OP_BEQZ:                             t = BRANCH;
                default:                                       t = NOP;
            endcase
        end
        return t;
    endfunction

    function automatic logic writes_reg(input itype_t t);
        return (t == RR_ALU) || (t == RM_ALU) || (t == LOAD);
    endfunction

endpackage

// File: rtl/mips32_alu_if.sv
// Operand/result bundle between the EX stage and the combinational ALU.
interface mips32_alu_if;
    logic [5:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] y;

    modport master (output opcode, a, b, imm, input y);
    modport slave  (input opcode, a, b, imm, output y);
endinterface

// File: rtl/mips32_alu.sv
// Combinational ALU: register-register ops, immediate ops and the
// base+offset address for loads/stores.
module mips32_alu
    import mips32_pkg::*;
(
    mips32_alu_if.slave alu
);

    always_comb begin
        // NOTE: default first so every path assigns y and no latch is inferred.
        alu.y = '0;
        case (alu.opcode)
            OP_ADD:               alu.y = alu.a + alu.b;
            OP_SUB:               alu.y = alu.a - alu.b;
            OP_AND:               alu.y = alu.a & alu.b;
            OP_OR:                alu.y = alu.a | alu.b;
            OP_SLT:               alu.y = {31'd0, $signed(alu.a) < $signed(alu.b)};
            OP_MUL:               alu.y = alu.a * alu.b;
            OP_ADDI, OP_LW, OP_SW: alu.y = alu.a + alu.imm;
            OP_SUBI:              alu.y = alu.a - alu.imm;
            OP_SLTI:              alu.y = {31'd0, $signed(alu.a) < $signed(alu.imm)};
            default:              alu.y = '0;
        endcase
    end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS32-subset core (IF/ID/EX/MEM/WB) with internal
// register file, unified word-addressed memory, forwarding and no stalls.
module pipe_mips32
    import mips32_pkg::*;
#(
    parameter int         MEM_DEPTH = 1024,
    parameter logic [5:0] HALT_OP   = 6'b111111
) (
    input  logic clk,
    input  logic rst_n,
    output logic halted
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:MEM_DEPTH-1];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;
    logic        halt_seen;

    logic        if_id_valid;
    logic [31:0] if_id_ir, if_id_npc;

    itype_t      id_ex_type;
    logic [5:0]  id_ex_op;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dest;
    logic [31:0] id_ex_a, id_ex_b, id_ex_imm, id_ex_npc;

    itype_t      ex_mem_type;
    logic [4:0]  ex_mem_dest;
    logic [31:0] ex_mem_alu, ex_mem_b;

    itype_t      mem_wb_type;
    logic [4:0]  mem_wb_dest;
    logic [31:0] mem_wb_result;

    // ID: decode plus same-cycle WB bypass into the register read.
    itype_t      id_type;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic [31:0] id_a, id_b;
    logic        wb_we;

    assign wb_we   = writes_reg(mem_wb_type) && (mem_wb_dest != 5'd0) && !HALTED;
    assign id_type = if_id_valid ? decode_type(f_op(if_id_ir), HALT_OP) : NOP;
    assign id_rs   = f_rs(if_id_ir);
    assign id_rt   = f_rt(if_id_ir);
    assign id_dest = (id_type == RR_ALU) ? f_rd(if_id_ir) : f_rt(if_id_ir);
    assign id_a    = (wb_we && mem_wb_dest == id_rs) ? mem_wb_result : Reg[id_rs];
    assign id_b    = (wb_we && mem_wb_dest == id_rt) ? mem_wb_result : Reg[id_rt];

    // EX: operand forwarding, youngest producer first. Load data is only
    // available from MEM/WB, so a load's direct successor sees the stale value.
    logic        ex_fwd;
    logic [31:0] fwd_a, fwd_b, ex_result, br_target;
    logic        br_taken;

    assign ex_fwd = ((ex_mem_type == RR_ALU) || (ex_mem_type == RM_ALU)) && (ex_mem_dest != 5'd0);

    always_comb begin
        fwd_a = id_ex_a;
        if (ex_fwd && ex_mem_dest == id_ex_rs)     fwd_a = ex_mem_alu;
        else if (wb_we && mem_wb_dest == id_ex_rs) fwd_a = mem_wb_result;
        fwd_b = id_ex_b;
        if (ex_fwd && ex_mem_dest == id_ex_rt)     fwd_b = ex_mem_alu;
        else if (wb_we && mem_wb_dest == id_ex_rt) fwd_b = mem_wb_result;
    end

    mips32_alu_if alu_bus ();
    mips32_alu    u_alu (.alu(alu_bus.slave));

    assign alu_bus.opcode = id_ex_op;
    assign alu_bus.a      = fwd_a;
    assign alu_bus.b      = fwd_b;
    assign alu_bus.imm    = id_ex_imm;
    assign ex_result      = alu_bus.y;

    always_comb begin
        br_taken = 1'b0;
        if (id_ex_type == BRANCH) begin
            if (id_ex_op == OP_BEQZ) br_taken = (fwd_a == 32'd0);
            else                     br_taken = (fwd_a != 32'd0);
        end
    end
    assign br_target = id_ex_npc + id_ex_imm;

    // MEM: combinational read; the write happens at the clock edge below.
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_result;
    logic          fetch_en;

    assign mem_addr   = ex_mem_alu[AW-1:0];
    assign mem_result = (ex_mem_type == LOAD) ? Mem[mem_addr] : ex_mem_alu;
    assign fetch_en   = !HALTED && !halt_seen && (id_type != HALT);

    // NOTE: pipeline state uses non-blocking assignments so every stage
    // samples the values of the previous cycle regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC            <= '0;
            HALTED        <= 1'b0;
            TAKEN_BRANCH  <= 1'b0;
            halt_seen     <= 1'b0;
            if_id_valid   <= 1'b0;
            if_id_ir      <= '0;
            if_id_npc     <= '0;
            id_ex_type    <= NOP;
            id_ex_op      <= '0;
            id_ex_rs      <= '0;
            id_ex_rt      <= '0;
            id_ex_dest    <= '0;
            id_ex_a       <= '0;
            id_ex_b       <= '0;
            id_ex_imm     <= '0;
            id_ex_npc     <= '0;
            ex_mem_type   <= NOP;
            ex_mem_dest   <= '0;
            ex_mem_alu    <= '0;
            ex_mem_b      <= '0;
            mem_wb_type   <= NOP;
            mem_wb_dest   <= '0;
            mem_wb_result <= '0;
        end else begin
            TAKEN_BRANCH <= br_taken;

            if (br_taken) begin
                PC          <= br_target;
                if_id_valid <= 1'b0;
            end else if (fetch_en) begin
                if_id_ir    <= Mem[PC[AW-1:0]];
                if_id_npc   <= PC + 32'd1;
                PC          <= PC + 32'd1;
                if_id_valid <= 1'b1;
            end else begin
                if_id_valid <= 1'b0;
            end

            id_ex_type <= br_taken ? NOP : id_type;
            if (!br_taken && id_type == HALT) halt_seen <= 1'b1;
            id_ex_op   <= f_op(if_id_ir);
            id_ex_rs   <= id_rs;
            id_ex_rt   <= id_rt;
            id_ex_dest <= id_dest;
            id_ex_a    <= id_a;
            id_ex_b    <= id_b;
            id_ex_imm  <= f_imm(if_id_ir);
            id_ex_npc  <= if_id_npc;

            ex_mem_type <= id_ex_type;
            ex_mem_dest <= id_ex_dest;
            ex_mem_alu  <= ex_result;
            ex_mem_b    <= fwd_b;

            mem_wb_type   <= ex_mem_type;
            mem_wb_dest   <= ex_mem_dest;
            mem_wb_result <= mem_result;

            if (mem_wb_type == HALT) HALTED <= 1'b1;
        end
    end

    // NOTE: register file and memory are deliberately not reset so that
    // preloaded programs and data survive rst_n.
    always_ff @(posedge clk) begin
        if (wb_we) Reg[mem_wb_dest] <= mem_wb_result;
        if (ex_mem_type == STORE && !HALTED) Mem[mem_addr] <= ex_mem_b;
    end

    assign halted = HALTED;

endmodule

// File: tb/tb_pipe_mips32.sv
// Self-checking bench: directed and random programs run on pipe_mips32 and on
// a sequential instruction-set interpreter; final architectural state compared.
module tb_pipe_mips32;
    import mips32_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic halted;

    always #5 clk = ~clk;

    pipe_mips32 #(.MEM_DEPTH(1024), .HALT_OP(6'b111111)) dut (
        .clk(clk), .rst_n(rst_n), .halted(halted)
    );

    mips32_alu_if alu_tb ();
    mips32_alu    u_alu_chk (.alu(alu_tb.slave));

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_reg [32];
    logic [31:0] m_mem [1024];
    int          m_taken;
    logic [31:0] m_hlt;
    int          last_cycles;
    int          last_pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    localparam logic [31:0] HLT_W = {6'b111111, 26'd0};

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm);
        logic [63:0] prod;
        prod = {32'd0, a} * {32'd0, b};
        case (op)
            OP_ADD:                return a + b;
            OP_SUB:                return a - b;
            OP_AND:                return a & b;
            OP_OR:                 return a | b;
            OP_SLT:                return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_MUL:                return prod[31:0];
            OP_ADDI, OP_LW, OP_SW: return a + imm;
            OP_SUBI:               return a - imm;
            OP_SLTI:               return ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            default:               return 32'd0;
        endcase
    endfunction

    // Sequential ISA interpreter: one instruction at a time, no pipeline.
    task automatic run_model();
        logic [31:0] pc, ir, a, b, imm, nxt;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        pc = 0;
        m_taken = 0;
        m_hlt = 32'hffff_ffff;
        for (int s = 0; s < 2000; s++) begin
            ir  = m_mem[pc[9:0]];
            op  = ir[31:26];
            rs  = ir[25:21];
            rt  = ir[20:16];
            rd  = ir[15:11];
            imm = {{16{ir[15]}}, ir[15:0]};
            a   = m_reg[rs];
            b   = m_reg[rt];
            nxt = pc + 1;
            if (op == 6'b111111) begin
                m_hlt = pc;
                break;
            end
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL:
                    if (rd != 0) m_reg[rd] = ref_alu(op, a, b, imm);
                OP_ADDI, OP_SUBI, OP_SLTI:
                    if (rt != 0) m_reg[rt] = ref_alu(op, a, b, imm);
                OP_LW: begin
                    nxt = a + imm;
                    if (rt != 0) m_reg[rt] = m_mem[nxt[9:0]];
                    nxt = pc + 1;
                end
                OP_SW: begin
                    nxt = a + imm;
                    m_mem[nxt[9:0]] = b;
                    nxt = pc + 1;
                end
                OP_BNEQZ: if (a != 0) begin nxt = pc + 1 + imm; m_taken++; end
                OP_BEQZ:  if (a == 0) begin nxt = pc + 1 + imm; m_taken++; end
                default: ;
            endcase
            pc = nxt;
        end
    endtask

    task automatic init_model(input bit rand_regs);
        for (int k = 0; k < 32; k++) m_reg[k] = (rand_regs && k != 0) ? $urandom : 32'(k);
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'd0;
    endtask

    // Loads DUT state from the model arrays, runs to halt, then compares.
    task automatic run_test(input string tag, input int bound, input int reset_at);
        int          cyc;
        int          pulses;
        logic [31:0] pc_halt;
        rst_n = 1'b0;
        for (int k = 0; k < 32; k++) dut.Reg[k] = m_reg[k];
        for (int i = 0; i < 1024; i++) dut.Mem[i] = m_mem[i];
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        pulses = 0;
        while (!halted && cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (dut.TAKEN_BRANCH) pulses++;
            if (reset_at > 0 && cyc == reset_at) begin
                #1 rst_n = 1'b0;
                #1;
                check({tag, " rst_pc"}, dut.PC, 32'd0);
                check({tag, " rst_halted"}, {31'd0, halted}, 32'd0);
                check({tag, " rst_reg20"}, dut.Reg[20], m_reg[20]);
                check({tag, " rst_mem300"}, dut.Mem[300], m_mem[300]);
                @(negedge clk);
                rst_n = 1'b1;
                cyc = 0;
                pulses = 0;
                reset_at = 0;
            end
        end
        last_cycles = cyc;
        last_pulses = pulses;
        check({tag, " halted"}, {31'd0, halted}, 32'd1);
        pc_halt = dut.PC;
        repeat (8) @(negedge clk);
        run_model();
        check({tag, " pc_frozen"}, dut.PC, pc_halt);
        check({tag, " pc_after_hlt"},
              {31'd0, (pc_halt == m_hlt + 1) || (pc_halt == m_hlt + 2)}, 32'd1);
        check({tag, " taken"}, 32'(pulses), 32'(m_taken));
        for (int k = 0; k < 32; k++)
            check($sformatf("%s R%0d", tag, k), dut.Reg[k], m_reg[k]);
        for (int i = 0; i < 1024; i++)
            check($sformatf("%s M%0d", tag, i), dut.Mem[i], m_mem[i]);
    endtask

    task automatic gen_random(input int n);
        int          addr;
        int          kind;
        logic [5:0]  op;
        logic [5:0]  rr_ops [6] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
        logic [5:0]  rm_ops [3] = '{OP_ADDI, OP_SUBI, OP_SLTI};
        addr = 0;
        for (int i = 512; i < 528; i++) m_mem[i] = $urandom;
        for (int j = 0; j < n; j++) begin
            kind = $urandom_range(0, 10);
            if (kind <= 5) begin
                op = rr_ops[$urandom_range(0, 5)];
                m_mem[addr++] = rr(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            end else if (kind <= 7) begin
                op = rm_ops[$urandom_range(0, 2)];
                m_mem[addr++] = ri(op, $urandom_range(0, 7), $urandom_range(0, 7),
                                   int'($urandom_range(0, 40)) - 20);
            end else if (kind == 8) begin
                m_mem[addr++] = ri(OP_LW, $urandom_range(0, 7), 0, 512 + $urandom_range(0, 15));
                m_mem[addr++] = {6'd20, 26'd0};
            end else if (kind == 9) begin
                m_mem[addr++] = ri(OP_SW, $urandom_range(0, 7), 0, 512 + $urandom_range(0, 15));
            end else begin
                m_mem[addr++] = {6'd7, 26'h155};
            end
        end
        m_mem[addr] = HLT_W;
    endtask

    initial begin
        logic [5:0]  alu_ops [9] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL,
                                     OP_ADDI, OP_SUBI, OP_SLTI};
        logic [31:0] imm;

        #2 rst_n = 1'b0;
        #1;
        check("reset pc", dut.PC, 32'd0);
        check("reset halted", {31'd0, halted}, 32'd0);
        check("reset taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

        for (int i = 0; i < 27; i++) begin
            imm = {{16{1'b0}}, 16'($urandom)};
            imm = {{16{imm[15]}}, imm[15:0]};
            alu_tb.opcode = alu_ops[i % 9];
            alu_tb.a      = (i < 9) ? 32'h8000_0000 : $urandom;
            alu_tb.b      = (i < 9) ? 32'h7fff_ffff : $urandom;
            alu_tb.imm    = imm;
            #1;
            check($sformatf("alu op%0d #%0d", alu_tb.opcode, i), alu_tb.y,
                  ref_alu(alu_tb.opcode, alu_tb.a, alu_tb.b, imm));
        end

        init_model(1'b0);
        m_mem[120] = 32'd85;
        m_mem[0] = ri(OP_ADDI, 1, 0, 120);
        m_mem[1] = rr(OP_OR, 3, 3, 3);
        m_mem[2] = ri(OP_LW, 2, 1, 0);
        m_mem[3] = rr(OP_OR, 3, 3, 3);
        m_mem[4] = ri(OP_ADDI, 2, 2, 45);
        m_mem[5] = rr(OP_OR, 3, 3, 3);
        m_mem[6] = ri(OP_SW, 2, 1, 1);
        m_mem[7] = HLT_W;
        run_test("load_store", 200, 0);
        check("load_store mem121", dut.Mem[121], 32'd130);
        check("load_store r1", dut.Reg[1], 32'd120);
        check("load_store r2", dut.Reg[2], 32'd130);
        check("load_store within20", {31'd0, last_cycles <= 20}, 32'd1);

        init_model(1'b0);
        m_mem[0] = ri(OP_ADDI, 1, 0, 10);
        m_mem[1] = rr(OP_ADD, 2, 1, 1);
        m_mem[2] = rr(OP_SUB, 3, 2, 1);
        m_mem[3] = HLT_W;
        run_test("alu_dep", 200, 0);
        check("alu_dep r2", dut.Reg[2], 32'd20);
        check("alu_dep r3", dut.Reg[3], 32'd10);

        init_model(1'b0);
        m_mem[0]  = ri(OP_ADDI, 1, 0, 3);
        m_mem[1]  = ri(OP_ADDI, 2, 0, 0);
        m_mem[2]  = ri(OP_BNEQZ, 0, 1, 2);
        m_mem[3]  = ri(OP_ADDI, 8, 8, 1);
        m_mem[4]  = ri(OP_ADDI, 9, 9, 1);
        m_mem[5]  = ri(OP_ADDI, 2, 2, 7);
        m_mem[6]  = ri(OP_SUBI, 1, 1, 1);
        m_mem[7]  = ri(OP_BNEQZ, 0, 1, -3);
        m_mem[8]  = ri(OP_ADDI, 6, 6, 1);
        m_mem[9]  = ri(OP_ADDI, 7, 7, 1);
        m_mem[10] = HLT_W;
        run_test("loop", 300, 0);
        check("loop r1", dut.Reg[1], 32'd0);
        check("loop r2", dut.Reg[2], 32'd21);
        check("loop r8", dut.Reg[8], 32'd8);
        check("loop r6", dut.Reg[6], 32'd7);
        check("loop pulses", 32'(last_pulses), 32'd3);

        init_model(1'b0);
        m_mem[0] = ri(OP_ADDI, 1, 0, 7);
        m_mem[1] = HLT_W;
        m_mem[2] = ri(OP_SW, 1, 0, 200);
        m_mem[3] = ri(OP_ADDI, 3, 0, 55);
        run_test("after_hlt", 200, 0);
        check("after_hlt mem200", dut.Mem[200], 32'd0);
        check("after_hlt r3", dut.Reg[3], 32'd3);

        init_model(1'b0);
        m_mem[0] = ri(OP_ADDI, 0, 0, 5);
        m_mem[1] = rr(OP_ADD, 1, 0, 0);
        m_mem[2] = HLT_W;
        run_test("r0", 200, 0);
        check("r0 r0", dut.Reg[0], 32'd0);
        check("r0 r1", dut.Reg[1], 32'd0);

        init_model(1'b0);
        m_mem[300] = 32'hdead_beef;
        m_mem[0]  = ri(OP_ADDI, 1, 0, 3);
        m_mem[1]  = ri(OP_ADDI, 2, 0, 0);
        m_mem[2]  = ri(OP_BNEQZ, 0, 1, 2);
        m_mem[3]  = ri(OP_ADDI, 8, 8, 1);
        m_mem[4]  = ri(OP_ADDI, 9, 9, 1);
        m_mem[5]  = ri(OP_ADDI, 2, 2, 7);
        m_mem[6]  = ri(OP_SUBI, 1, 1, 1);
        m_mem[7]  = ri(OP_BNEQZ, 0, 1, -3);
        m_mem[8]  = ri(OP_ADDI, 6, 6, 1);
        m_mem[9]  = ri(OP_ADDI, 7, 7, 1);
        m_mem[10] = HLT_W;
        run_test("midreset", 300, 8);
        check("midreset r1", dut.Reg[1], 32'd0);
        check("midreset r2", dut.Reg[2], 32'd21);

        for (int t = 0; t < 20; t++) begin
            init_model(1'b1);
            gen_random(14);
            run_test($sformatf("rand%0d", t), 300, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
